// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StRedirect = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the
// instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       use_rs1_id,
    input  logic       use_rs2_id,
    input  logic [4:0] rd_ex,
    input  logic       memtoreg_ex,
    input  logic       wb_reg_file_ex,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = use_rs1_id && (rs1_id == rd_ex);
        rs2_hit  = use_rs2_id && (rs2_id == rd_ex);
        // x0 is never a real dependency
        load_use = memtoreg_ex && wb_reg_file_ex && (rd_ex != REG_ZERO) &&
                   (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes on data-memory wait, redirects on
// mispredict, inserts one bubble on load-use, and counts stalls and redirects.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             memtoreg_ex,
    input  logic             wb_reg_file_ex,
    input  logic             mispredict_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned RcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [RcW-1:0] RcLoad = RcW'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [RcW-1:0]   rc_q, rc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             mem_wait;
    logic             in_redirect;

    hazard_detect u_hazard_detect (
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .use_rs1_id     (use_rs1_id),
        .use_rs2_id     (use_rs2_id),
        .rd_ex          (rd_ex),
        .memtoreg_ex    (memtoreg_ex),
        .wb_reg_file_ex (wb_reg_file_ex),
        .load_use       (load_use)
    );

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        redirect    = 1'b0;
        state_d     = StRun;
        rc_d        = rc_q;
        flush_cnt_d = flush_cnt_q;

        mem_wait    = dmem_req_mem && !dmem_ready;
        // A freeze entered from REDIRECT keeps the remaining count and resumes it afterwards
        in_redirect = (state_q == StRedirect) || ((state_q == StMemWait) && (rc_q != '0));

        if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = StMemWait;
        end else if (mispredict_ex) begin
            redirect    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            rc_d        = RcLoad;
            state_d     = (FLUSH_CYCLES > 1) ? StRedirect : StRun;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (in_redirect) begin
            ifid_flush = 1'b1;
            rc_d       = rc_q - RcW'(1);
            state_d    = (rc_q == RcW'(1)) ? StRun : StRedirect;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            redirect   = 1'b0;
        end

        stall_cnt_d = pc_en ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            rc_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (FLUSH_CYCLES=3/CNT_W=32 and FLUSH_CYCLES=1/CNT_W=4)
// checked against vector tables, directed sequences and a rule-level reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       use_rs1_id, use_rs2_id, memtoreg_ex, wb_reg_file_ex;
    logic       mispredict_ex, dmem_req_mem, dmem_ready;

    logic        pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a;
    logic        ifid_flush_a, idex_flush_a, redirect_a;
    logic [31:0] stall_cnt_a, flush_cnt_a;
    logic        pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
    logic        ifid_flush_b, idex_flush_b, redirect_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    logic [7:0] out_a, out_b;
    assign out_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a,
                    ifid_flush_a, idex_flush_a, redirect_a};
    assign out_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b,
                    ifid_flush_b, idex_flush_b, redirect_b};

    localparam logic [7:0] ONORM = 8'b11111000;
    localparam logic [7:0] OLU   = 8'b00111010;
    localparam logic [7:0] OMP   = 8'b11111111;
    localparam logic [7:0] ORED  = 8'b11111100;
    localparam logic [7:0] OFRZ  = 8'b00000000;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
        .memtoreg_ex(memtoreg_ex), .wb_reg_file_ex(wb_reg_file_ex),
        .mispredict_ex(mispredict_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a), .exmem_en(exmem_en_a),
        .memwb_en(memwb_en_a), .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
        .redirect(redirect_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
        .memtoreg_ex(memtoreg_ex), .wb_reg_file_ex(wb_reg_file_ex),
        .mispredict_ex(mispredict_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
        .memwb_en(memwb_en_b), .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
        .redirect(redirect_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining IF/ID-flush cycles and unbounded counts per instance
    int          m_left[2];
    logic [63:0] m_stall[2];
    logic [63:0] m_flush[2];

    function automatic int fcyc(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic logic model_lu();
        return memtoreg_ex && wb_reg_file_ex && (rd_ex != 5'd0) &&
               ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
    endfunction

    function automatic logic [7:0] model_out(input int i);
        if (rst) return OFRZ;
        if (dmem_req_mem && !dmem_ready) return OFRZ;
        if (mispredict_ex) return OMP;
        if (m_left[i] > 0) return ORED;
        if (model_lu()) return OLU;
        return ONORM;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [7:0] o;
            o = model_out(i);
            if (!o[7]) m_stall[i]++;
            if (dmem_req_mem && !dmem_ready) begin
            end else if (mispredict_ex) begin
                m_flush[i]++;
                m_left[i] = fcyc(i) - 1;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " outs_a"}, out_a, model_out(0));
        chk({tag, " outs_b"}, out_b, model_out(1));
        chk({tag, " stall_a"}, stall_cnt_a, m_stall[0] & 64'hFFFF_FFFF);
        chk({tag, " flush_a"}, flush_cnt_a, m_flush[0] & 64'hFFFF_FFFF);
        chk({tag, " stall_b"}, stall_cnt_b, m_stall[1] & 64'hF);
        chk({tag, " flush_b"}, flush_cnt_b, m_flush[1] & 64'hF);
    endtask

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; memtoreg_ex = 1'b0; wb_reg_file_ex = 1'b0;
        mispredict_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu();
        idle();
        rs1_id = 5'd5; rd_ex = 5'd5; use_rs1_id = 1'b1; memtoreg_ex = 1'b1; wb_reg_file_ex = 1'b1;
    endtask

    // Inputs are applied 1 time unit after a rising edge; checks land mid-cycle.
    task automatic run_cycle(input string tag);
        #3;
        check_all(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_exp(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        #3;
        chk({tag, " a"}, out_a, ea);
        chk({tag, " b"}, out_b, eb);
        check_all(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        chk("reset outs_a", out_a, OFRZ);
        chk("reset outs_b", out_b, OFRZ);
        chk("reset stall_a", stall_cnt_a, 0);
        chk("reset flush_a", flush_cnt_a, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mtr, wb, mp, req, rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ONORM};
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OLU};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ONORM};
        vecs[3]  = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OLU};
        vecs[4]  = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ONORM};
        vecs[5]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ONORM};
        vecs[6]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ONORM};
        vecs[7]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, OMP};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OFRZ};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ONORM};
        vecs[10] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, OFRZ};

        idle();
        rst = 1'b1;
        model_reset();
        #2;
        do_reset();
        cyc_exp("first cycle", ONORM, ONORM);

        // Table vectors, each from a drained RUN state
        for (int v = 0; v < 11; v++) begin
            rs1_id = vecs[v].rs1; rs2_id = vecs[v].rs2; rd_ex = vecs[v].rd;
            use_rs1_id = vecs[v].u1; use_rs2_id = vecs[v].u2;
            memtoreg_ex = vecs[v].mtr; wb_reg_file_ex = vecs[v].wb;
            mispredict_ex = vecs[v].mp; dmem_req_mem = vecs[v].req; dmem_ready = vecs[v].rdy;
            cyc_exp($sformatf("vec%0d", v), vecs[v].exp, vecs[v].exp);
            idle();
            for (int k = 0; k < 3; k++) run_cycle($sformatf("vec%0d drain", v));
        end

        // Load-use stalls exactly one cycle; rd=x0 never stalls
        do_reset();
        set_lu();
        cyc_exp("lu", OLU, OLU);
        idle();
        cyc_exp("lu next", ONORM, ONORM);
        chk("lu stall_cnt", stall_cnt_a, 1);
        set_lu(); rd_ex = 5'd0; rs1_id = 5'd0;
        cyc_exp("lu x0", ONORM, ONORM);
        chk("lu x0 stall_cnt", stall_cnt_a, 1);

        // Mispredict with 3 flush cycles on dut, 1 on dut4
        do_reset();
        mispredict_ex = 1'b1;
        cyc_exp("mp", OMP, OMP);
        idle();
        cyc_exp("mp+1", ORED, ONORM);
        cyc_exp("mp+2", ORED, ONORM);
        cyc_exp("mp+3", ONORM, ONORM);
        chk("mp flush_cnt", flush_cnt_a, 1);
        chk("mp flush_cnt4", flush_cnt_b, 1);

        // Freeze hides a pending mispredict until ready
        do_reset();
        mispredict_ex = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) cyc_exp("freeze mp", OFRZ, OFRZ);
        chk("freeze no redirect", flush_cnt_a, 0);
        dmem_ready = 1'b1;
        cyc_exp("freeze release", OMP, OMP);
        idle();
        chk("freeze stall_cnt", stall_cnt_a, 4);
        chk("freeze flush_cnt", flush_cnt_a, 1);
        cyc_exp("post release", ORED, ONORM);

        // Freeze during REDIRECT holds the remaining flush count
        do_reset();
        mispredict_ex = 1'b1;
        cyc_exp("rf mp", OMP, OMP);
        idle(); dmem_req_mem = 1'b1;
        cyc_exp("rf frz1", OFRZ, OFRZ);
        cyc_exp("rf frz2", OFRZ, OFRZ);
        idle();
        cyc_exp("rf red1", ORED, ONORM);
        cyc_exp("rf red2", ORED, ONORM);
        cyc_exp("rf run", ONORM, ONORM);

        // Asynchronous reset in the middle of a freeze
        idle(); dmem_req_mem = 1'b1;
        cyc_exp("pre-rst frz1", OFRZ, OFRZ);
        cyc_exp("pre-rst frz2", OFRZ, OFRZ);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst outs_a", out_a, OFRZ);
        chk("midrst stall_a", stall_cnt_a, 0);
        chk("midrst stall_b", stall_cnt_b, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        cyc_exp("after midrst", ONORM, ONORM);
        chk("after midrst stall", stall_cnt_a, 0);

        // 4-bit counter wrap after 17 stalls
        do_reset();
        for (int k = 0; k < 17; k++) begin
            set_lu();
            run_cycle("wrap lu");
            idle();
            run_cycle("wrap idle");
        end
        chk("wrap stall_cnt4", stall_cnt_b, 1);
        chk("wrap stall_cnt32", stall_cnt_a, 17);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rs1_id = 5'($urandom_range(0, 5));
            rs2_id = 5'($urandom_range(0, 5));
            rd_ex = 5'($urandom_range(0, 5));
            use_rs1_id = 1'($urandom_range(0, 1));
            use_rs2_id = 1'($urandom_range(0, 1));
            memtoreg_ex = 1'($urandom_range(0, 1));
            wb_reg_file_ex = ($urandom_range(0, 3) != 0);
            mispredict_ex = ($urandom_range(0, 7) == 0);
            dmem_req_mem = ($urandom_range(0, 2) == 0);
            dmem_ready = 1'($urandom_range(0, 1));
            run_cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
